// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: captures a cipher key on start and streams round keys 0..NR, one per clock.
// Optional round-key register bank enabled by defining KEY_EXP_STORE_EN.
module key_expansion #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_index,
    output logic             rk_valid,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       rk_rd_addr,
    output logic [KEY_W-1:0] rk_rd_data
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] rk_out_q, rk_out_d;
    logic [3:0]       rk_index_q, rk_index_d;
    logic             rk_valid_q, rk_valid_d;
    logic [KEY_W-1:0] next_key;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;
        w0  = key_q[127:96];
        w1  = key_q[95:64];
        w2  = key_q[63:32];
        w3  = key_q[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t   = sub ^ {rcon_q, 24'h0};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // busy stays high through the cycle carrying the last key, so a start coincident with done is dropped.
    assign busy     = (state_q != IDLE) | rk_valid_q;
    assign done     = rk_valid_q & (rk_index_q == 4'(NR));
    assign rk_out   = rk_out_q;
    assign rk_index = rk_index_q;
    assign rk_valid = rk_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        key_d      = key_q;
        rk_out_d   = rk_out_q;
        rk_index_d = rk_index_q;
        rk_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !busy) begin
                    key_d   = key_in;
                    cnt_d   = 4'd0;
                    rcon_d  = 8'h01;
                    state_d = RUN;
                end
            end
            RUN: begin
                rk_out_d   = key_q;
                rk_index_d = cnt_q;
                rk_valid_d = 1'b1;
                key_d      = next_key;
                rcon_d     = xtime(rcon_q);
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'(NR)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rcon_q     <= '0;
            key_q      <= '0;
            rk_out_q   <= '0;
            rk_index_q <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rcon_q     <= rcon_d;
            key_q      <= key_d;
            rk_out_q   <= rk_out_d;
            rk_index_q <= rk_index_d;
            rk_valid_q <= rk_valid_d;
        end
    end

`ifdef KEY_EXP_STORE_EN
    logic [KEY_W-1:0] bank_q [NR+1];
    logic [KEY_W-1:0] bank_d [NR+1];

    // Entry i lands on the same edge that presents key i on rk_out.
    always_comb begin
        bank_d = bank_q;
        if (state_q == RUN) bank_d[cnt_q] = key_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bank_q <= '{default: '0};
        else     bank_q <= bank_d;
    end

    always_comb begin
        rk_rd_data = '0;
        if (rk_rd_addr <= 4'(NR)) rk_rd_data = bank_q[rk_rd_addr];
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rk_rd_addr;
    assign rk_rd_data     = '0;
`endif

endmodule
